// File: rtl/ramresp_pkg.sv
// Shared definitions for the RAM responder: FSM encodings, LFSR constants and step function.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ramresp_pkg;

  // Bus geometry as seen by the initiator
  localparam int BUS_AW = 27;
  localparam int DATA_W = 32;

  // Galois LFSR feedback mask, identical to the test generator's generator
  localparam logic [31:0] LFSR_MASK = 32'hD000_0001;
  localparam logic [31:0] LFSR_DEFAULT_SEED = 32'hC703_37DB;

  // Responder FSM encodings, shared with the test generator
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  // One step of the right-shifting Galois LFSR
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    logic [31:0] s;
    s = {1'b0, v[31:1]};
    if (v[0]) s = s ^ LFSR_MASK;
    return s;
  endfunction

endpackage

// File: rtl/ramresp_if.sv
// Strobe/ack data bus between the RAM test generator and the memory responder.
// Latency: n/a (wiring only).
// Backpressure: initiator holds stb until ack; responder pulses ack for one cycle.
interface ramresp_if;
  import ramresp_pkg::*;

  logic              stb;
  logic              we;
  logic [BUS_AW-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              ack;

  // Initiator side (test generator)
  modport master (
    output stb,
    output we,
    output addr,
    output data_in,
    input  data_out,
    input  ack
  );

  // Responder side (RAM model)
  modport slave (
    input  stb,
    input  we,
    input  addr,
    input  data_in,
    output data_out,
    output ack
  );

endinterface

// File: rtl/ramresp_lfsr.sv
// 32-bit right-shift Galois LFSR used to draw per-access extra wait cycles.
// Latency: value updates one cycle after next is sampled high.
// Backpressure: none; advances only when next is asserted.
module ramresp_lfsr
  import ramresp_pkg::*;
#(
  parameter logic [31:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        next,
  output logic [31:0] value
);

  // Hold the seed in reset, step once per request
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= SEED;
    end else if (next) begin
      value <= lfsr_step(value);
    end
  end

endmodule

// File: rtl/ramresp.sv
// Memory-side responder: word RAM answering stb/we requests after a programmable wait count.
// Latency: ack in cycle n+LATENCY+extra for stb first high in cycle n (extra 0..3 when RAND_WAIT).
// Backpressure: initiator holds stb until the single-cycle ack; stb dropping early abandons the access.
module ramresp
  import ramresp_pkg::*;
#(
  parameter int          AW        = 12,
  parameter int          LATENCY   = 2,
  parameter bit          RAND_WAIT = 1'b0,
  parameter logic [31:0] SEED      = LFSR_DEFAULT_SEED
) (
  input  logic     clk,
  input  logic     rst,
  ramresp_if.slave bus
);

  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  state_t              state_q, state_d;
  logic [7:0]          wcnt_q, wcnt_d;
  logic                we_q;
  logic [AW-1:0]       addr_q;
  logic [DATA_W-1:0]   dat_q;
  logic                capture;
  logic                commit;
  logic                lfsr_next;
  logic [31:0]         lfsr_val;
  logic [1:0]          extra;
  logic [7:0]          init_cnt;

  logic                acc_we;
  logic [AW-1:0]       acc_addr;
  logic [DATA_W-1:0]   acc_dat;

  logic                ack_q;
  logic [DATA_W-1:0]   dout_q;
  logic [DATA_W-1:0]   mem [2**AW];

  // Upper address bits alias away; only the low LFSR bits pick the extra waits
  logic                unused_bits;
  assign unused_bits = &{1'b0, bus.addr[BUS_AW-1:AW], lfsr_val[31:2]};

  ramresp_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .next  (lfsr_next),
    .value (lfsr_val)
  );

  assign extra    = RAND_WAIT ? lfsr_val[1:0] : 2'd0;
  assign init_cnt = LAT_M1 + {6'd0, extra};

  // Zero-wait accesses commit straight from IDLE, so use the live bus there
  assign acc_we   = (state_q == IDLE) ? bus.we            : we_q;
  assign acc_addr = (state_q == IDLE) ? bus.addr[AW-1:0]  : addr_q;
  assign acc_dat  = (state_q == IDLE) ? bus.data_in       : dat_q;

  // Next-state, wait counter and commit strobe
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    capture   = 1'b0;
    commit    = 1'b0;
    lfsr_next = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.stb) begin
          capture   = 1'b1;
          lfsr_next = 1'b1;
          wcnt_d    = init_cnt;
          if (init_cnt == 8'd0) begin
            state_d = ACK;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!bus.stb) begin
          // Initiator gave up: drop the access without writing or acking
          state_d = IDLE;
        end else if (wcnt_q == 8'd1) begin
          state_d = ACK;
          commit  = 1'b1;
          wcnt_d  = 8'd0;
        end else begin
          wcnt_d = wcnt_q - 8'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state and wait counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Latch the request so the bus may be ignored while waiting
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      dat_q  <= '0;
    end else if (capture) begin
      we_q   <= bus.we;
      addr_q <= bus.addr[AW-1:0];
      dat_q  <= bus.data_in;
    end
  end

  // RAM write port; contents survive reset, a reset cycle blocks the write
  always_ff @(posedge clk) begin
    if (commit && acc_we && !rst) begin
      mem[acc_addr] <= acc_dat;
    end
  end

  // Read data register, only refreshed by a completing read
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
    end else if (commit && !acc_we) begin
      dout_q <= mem[acc_addr];
    end
  end

  // Completion pulse, raised on the same edge that commits the access
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= commit;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.data_out = dout_q;

endmodule
